// File: rtl/div_unit.sv
// div_unit: multicycle signed restoring divider.
// Returns the quotient on lo and the remainder on hi, with truncation toward
// zero; the remainder takes the sign of the dividend. A zero divisor produces
// a one-cycle div0 pulse and leaves hi/lo untouched.
module div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  divStart,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  busy,
    output logic                  done,
    output logic                  div0,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // Magnitude on a W+1 bit path so the most negative operand is exact.
    function automatic logic [W:0] abs_ext(input logic [W-1:0] v);
        logic [W:0] ext;
        ext = {v[W-1], v};
        if (v[W-1]) begin
            abs_ext = (~ext) + {{W{1'b0}}, 1'b1};
        end else begin
            abs_ext = ext;
        end
    endfunction

    // Two's complement negation, wrapping mod 2^W.
    function automatic logic [W-1:0] neg_w(input logic [W-1:0] v);
        neg_w = (~v) + {{(W-1){1'b0}}, 1'b1};
    endfunction

    state_t           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [W-1:0]     rem_q,      rem_d;
    logic [W-1:0]     quot_q,     quot_d;
    logic [W:0]       dvsr_q,     dvsr_d;
    logic             quot_neg_q, quot_neg_d;
    logic             rem_neg_q,  rem_neg_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             div0_q,     div0_d;
    logic [W-1:0]     hi_q,       hi_d;
    logic [W-1:0]     lo_q,       lo_d;

    // Partial remainder shifted left with the next dividend bit brought in.
    logic [W:0] rem_sh_s;
    assign rem_sh_s = {rem_q, quot_q[W-1]};

    // Next-state and datapath: one restoring step per RUN cycle, signs in FIX.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        dvsr_d     = dvsr_q;
        quot_neg_d = quot_neg_q;
        rem_neg_d  = rem_neg_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div0_d     = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (divStart) begin
                    if (divisor == {W{1'b0}}) begin
                        div0_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        quot_neg_d = dividend[W-1] ^ divisor[W-1];
                        rem_neg_d  = dividend[W-1];
                        dvsr_d     = abs_ext(divisor);
                        quot_d     = W'(abs_ext(dividend));
                        rem_d      = {W{1'b0}};
                        cnt_d      = CNT_ZERO;
                        busy_d     = 1'b1;
                        state_d    = S_RUN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (rem_sh_s >= dvsr_q) begin
                    rem_d  = W'(rem_sh_s - dvsr_q);
                    quot_d = {quot_q[W-2:0], 1'b1};
                end else begin
                    rem_d  = W'(rem_sh_s);
                    quot_d = {quot_q[W-2:0], 1'b0};
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = CNT_ZERO;
                    state_d = S_FIX;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = S_RUN;
                end
            end
            S_FIX: begin
                if (quot_neg_q) begin
                    lo_d = neg_w(quot_q);
                end else begin
                    lo_d = quot_q;
                end
                if (rem_neg_q) begin
                    hi_d = neg_w(rem_q);
                end else begin
                    hi_d = rem_q;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                cnt_d   = CNT_ZERO;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= CNT_ZERO;
            rem_q      <= {W{1'b0}};
            quot_q     <= {W{1'b0}};
            dvsr_q     <= {(W+1){1'b0}};
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div0_q     <= 1'b0;
            hi_q       <= {W{1'b0}};
            lo_q       <= {W{1'b0}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            dvsr_q     <= dvsr_d;
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div0_q     <= div0_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign div0 = div0_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: table-driven self-checking bench with an expected-result queue.
module tb_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         divStart;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic         div0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    // 10 ns clock.
    always #5 clk = ~clk;

    div_unit #(.DATA_WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .divStart (divStart),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .div0     (div0),
        .hi       (hi),
        .lo       (lo)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dz;
    } vec_t;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dz;
    } exp_t;

    exp_t         sb[$];
    vec_t         tbl[11];
    int           n_vec   = 0;
    int           n_err   = 0;
    logic [W-1:0] held_hi = '0;
    logic [W-1:0] held_lo = '0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic start_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit push,
                             input logic [W-1:0] elo, input logic [W-1:0] ehi, input logic edz);
        exp_t e;
        if (push) begin
            e.lo = elo;
            e.hi = ehi;
            e.dz = edz;
            sb.push_back(e);
        end
        divStart = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        divStart = 1'b0;
    endtask

    // Waits for done/div0, pops the expected record and compares it.
    task automatic wait_result(input string name, input int already);
        int   cyc;
        int   bcnt;
        bit   seen;
        bit   bad_hold;
        exp_t e;
        cyc      = already;
        bcnt     = already;
        seen     = 1'b0;
        bad_hold = 1'b0;
        while (!seen && cyc <= 40) begin
            if (done || div0) begin
                seen = 1'b1;
            end else begin
                if (busy) bcnt++;
                if (hi !== held_hi || lo !== held_lo) bad_hold = 1'b1;
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        check({name, " hold"}, {31'd0, bad_hold}, 32'd0);
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s timeout: no done/div0 within 40 cycles", name);
        end else if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: unexpected output, scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            check({name, " lo"},      lo, e.lo);
            check({name, " hi"},      hi, e.hi);
            check({name, " div0"},    {31'd0, div0}, {31'd0, e.dz});
            check({name, " done"},    {31'd0, done}, {31'd0, ~e.dz});
            check({name, " busy"},    {31'd0, busy}, 32'd0);
            check({name, " latency"}, cyc,  e.dz ? 32'd0 : 32'd33);
            check({name, " busycnt"}, bcnt, e.dz ? 32'd0 : 32'd33);
            held_lo = e.lo;
            held_hi = e.hi;
            if (e.dz) begin
                @(posedge clk);
                #1;
                check({name, " div0 pulse"}, {31'd0, div0}, 32'd0);
                check({name, " no done"},    {31'd0, done}, 32'd0);
            end
        end
    endtask

    initial begin
        longint       sa;
        longint       sbv;
        logic [63:0]  q64;
        logic [63:0]  r64;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bit           stray;

        tbl[0]  = '{32'd7,          32'd2,          32'd3,          32'd1,          1'b0};
        tbl[1]  = '{32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
        tbl[2]  = '{32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
        tbl[3]  = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
        tbl[4]  = '{32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0};
        tbl[5]  = '{32'd7,          32'd2,          32'd3,          32'd1,          1'b0};
        tbl[6]  = '{32'd5,          32'd0,          32'd3,          32'd1,          1'b1};
        tbl[7]  = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
        tbl[8]  = '{32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  1'b0};
        tbl[9]  = '{32'h7FFF_FFFF,  32'h7FFF_FFFF,  32'd1,          32'd0,          1'b0};
        tbl[10] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};

        reset    = 1'b1;
        divStart = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset div0", {31'd0, div0}, 32'd0);
        check("reset hi",   hi, 32'd0);
        check("reset lo",   lo, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Table vectors, each started in the done cycle of the previous one.
        for (int i = 0; i < 11; i++) begin
            start_div(tbl[i].a, tbl[i].b, 1'b1, tbl[i].lo, tbl[i].hi, tbl[i].dz);
            wait_result($sformatf("vec%0d", i), 0);
        end

        // divStart while busy is ignored.
        start_div(32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("ignored busy", {31'd0, busy}, 32'd1);
        divStart = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd3;
        @(posedge clk);
        #1;
        divStart = 1'b0;
        wait_result("ignored", 5);

        // Reset in the middle of a division.
        start_div(32'd100, 32'd7, 1'b0, '0, '0, 1'b0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort hi",   hi, 32'd0);
        check("abort lo",   lo, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort div0", {31'd0, div0}, 32'd0);
        held_hi = '0;
        held_lo = '0;
        stray   = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || div0 || busy) stray = 1'b1;
        end
        check("abort quiet", {31'd0, stray}, 32'd0);
        start_div(32'd9, 32'd3, 1'b1, 32'd3, 32'd0, 1'b0);
        wait_result("after abort", 0);

        // reset and divStart on the same edge: reset wins.
        reset = 1'b1;
        start_div(32'd9, 32'd3, 1'b0, '0, '0, 1'b0);
        reset = 1'b0;
        check("rst+start busy", {31'd0, busy}, 32'd0);
        check("rst+start lo",   lo, 32'd0);
        @(posedge clk);
        #1;
        check("rst+start idle", {31'd0, busy}, 32'd0);
        held_hi = '0;
        held_lo = '0;

        // Random operands against a 64-bit reference.
        for (int k = 0; k < 8; k++) begin
            ra = $urandom;
            if (k % 2 == 0) begin
                rb = W'($urandom_range(1, 50));
                if ($urandom_range(0, 1) == 1) rb = -rb;
            end else begin
                rb = $urandom;
                if (rb == '0) rb = 32'd3;
            end
            sa  = longint'($signed(ra));
            sbv = longint'($signed(rb));
            q64 = sa / sbv;
            r64 = sa % sbv;
            start_div(ra, rb, 1'b1, q64[W-1:0], r64[W-1:0], 1'b0);
            wait_result($sformatf("rand%0d", k), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
